alu_scheduler: RTL and testbench

Shares the single clocked ALU datapath (4-bit A/B, 2-bit mode, 5-bit Y) among NUM_REQ independent requesters. Grants are round-robin, and only one operation is in flight at a time. The block drives the ALU operand/mode inputs, waits the ALU latency, and returns Y tagged with the requester index over a valid/ready response channel. It sits directly in front of the ALU instance, which shares its clk and rst_n.

---
 rtl/alu_sched_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 35 +++
 rtl/alu_scheduler.sv | 127 ++++++++++++
 tb/tb_alu_scheduler.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_sched_pkg.sv
// Shared types and widths for the ALU scheduler and its round-robin arbiter.
package alu_sched_pkg;

    localparam int OPND_W = 4;
    localparam int MODE_W = 2;
    localparam int RES_W  = 5;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first set request at or after ptr,
// with wrap-around, wins.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          any
);

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        // Walk from the farthest offset down so the closest hit to ptr is kept.
        for (int k = N - 1; k >= 0; k--) begin
            int idx;
            idx = int'(ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (req[idx]) begin
                any       = 1'b1;
                grant_idx = IW'(idx);
            end
        end
        if (any) begin
            grant[grant_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/alu_scheduler.sv
// Time-shares one ALU among NUM_REQ requesters: round-robin grant, one
// operation in flight, tagged result returned over a valid/ready channel.
module alu_scheduler
    import alu_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ALU_LAT = 1,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*OPND_W-1:0] req_a,
    input  logic [NUM_REQ*OPND_W-1:0] req_b,
    input  logic [NUM_REQ*MODE_W-1:0] req_mode,
    output logic [OPND_W-1:0]         alu_a,
    output logic [OPND_W-1:0]         alu_b,
    output logic [MODE_W-1:0]         alu_mode,
    input  logic [RES_W-1:0]          alu_y,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [ID_W-1:0]           rsp_id,
    output logic [RES_W-1:0]          rsp_y,
    output logic                      busy
);

    localparam int LAT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

    sched_state_t       state_reg;
    logic [ID_W-1:0]    rr_ptr_reg;
    logic [ID_W-1:0]    cur_id_reg;
    logic [LAT_W-1:0]   lat_cnt_reg;
    logic [OPND_W-1:0]  alu_a_reg;
    logic [OPND_W-1:0]  alu_b_reg;
    logic [MODE_W-1:0]  alu_mode_reg;
    logic               rsp_valid_reg;
    logic [ID_W-1:0]    rsp_id_reg;
    logic [RES_W-1:0]   rsp_y_reg;

    logic [OPND_W-1:0]  a_arr    [NUM_REQ];
    logic [OPND_W-1:0]  b_arr    [NUM_REQ];
    logic [MODE_W-1:0]  mode_arr [NUM_REQ];

    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_idx;
    logic               grant_any;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign a_arr[gi]    = req_a[gi*OPND_W +: OPND_W];
            assign b_arr[gi]    = req_b[gi*OPND_W +: OPND_W];
            assign mode_arr[gi] = req_mode[gi*MODE_W +: MODE_W];
        end
    endgenerate

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (ID_W)
    ) u_arb (
        .req       (req_valid),
        .ptr       (rr_ptr_reg),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any       (grant_any)
    );

    // Grants are only offered while idle, so an accept implies a free ALU.
    assign req_ready = (state_reg == IDLE) ? grant : '0;
    assign busy      = (state_reg != IDLE);

    assign alu_a     = alu_a_reg;
    assign alu_b     = alu_b_reg;
    assign alu_mode  = alu_mode_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_id    = rsp_id_reg;
    assign rsp_y     = rsp_y_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            rr_ptr_reg    <= '0;
            cur_id_reg    <= '0;
            lat_cnt_reg   <= '0;
            alu_a_reg     <= '0;
            alu_b_reg     <= '0;
            alu_mode_reg  <= '0;
            rsp_valid_reg <= 1'b0;
            rsp_id_reg    <= '0;
            rsp_y_reg     <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (grant_any) begin
                        alu_a_reg    <= a_arr[grant_idx];
                        alu_b_reg    <= b_arr[grant_idx];
                        alu_mode_reg <= mode_arr[grant_idx];
                        cur_id_reg   <= grant_idx;
                        lat_cnt_reg  <= LAT_W'(ALU_LAT - 1);
                        state_reg    <= WAIT;
                    end
                end
                WAIT: begin
                    if (lat_cnt_reg == '0) begin
                        rsp_y_reg     <= alu_y;
                        rsp_id_reg    <= cur_id_reg;
                        rsp_valid_reg <= 1'b1;
                        state_reg     <= RESP;
                    end else begin
                        lat_cnt_reg <= lat_cnt_reg - LAT_W'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        rr_ptr_reg    <= (cur_id_reg == ID_W'(NUM_REQ - 1)) ?
                                         '0 : cur_id_reg + ID_W'(1);
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_scheduler.sv
// Directed bench for alu_scheduler with NUM_REQ=4, ALU_LAT=1 and a behavioural ALU stub.
module tb_alu_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic [7:0]  req_mode;
    logic [3:0]  alu_a;
    logic [3:0]  alu_b;
    logic [1:0]  alu_mode;
    logic [4:0]  alu_y;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [4:0]  rsp_y;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // ALU_LAT=1: the result of the registered operands is usable at the next edge.
    always_comb begin
        case (alu_mode)
            2'b00:   alu_y = {1'b0, alu_a} + {1'b0, alu_b};
            2'b01:   alu_y = {1'b0, alu_a} - {1'b0, alu_b};
            2'b10:   alu_y = {1'b0, alu_a & alu_b};
            default: alu_y = {1'b0, alu_a | alu_b};
        endcase
    end

    alu_scheduler #(
        .NUM_REQ (4),
        .ALU_LAT (1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_mode  (req_mode),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_mode  (alu_mode),
        .alu_y     (alu_y),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_y     (rsp_y),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [3:0] a, input logic [3:0] b,
                           input logic [1:0] m);
        req_a[4*i +: 4]    = a;
        req_b[4*i +: 4]    = b;
        req_mode[2*i +: 2] = m;
    endtask

    // One full transaction with rsp_ready held high: grant, wait, respond, complete.
    task automatic run_op(input int g, input logic [4:0] y);
        #1;
        check("grant", 32'(req_ready), 32'(1) << g);
        tick();
        check("busy_wait", 32'(busy), 32'd1);
        tick();
        check("rsp_valid", 32'(rsp_valid), 32'd1);
        check("rsp_id", 32'(rsp_id), 32'(g));
        check("rsp_y", 32'(rsp_y), 32'(y));
        $display("op: grant=%0d rsp_id=%0d rsp_y=%0d", g, rsp_id, rsp_y);
        tick();
        check("rsp_done", 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_mode  = '0;
        rsp_ready = 1'b0;
        tick();
        tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_alu_a", 32'(alu_a), 32'd0);
        check("rst_alu_b", 32'(alu_b), 32'd0);
        check("rst_alu_mode", 32'(alu_mode), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_y", 32'(rsp_y), 32'd0);
        check("rst_rsp_id", 32'(rsp_id), 32'd0);

        // Single request with rsp_ready low at first.
        rst_n = 1'b1;
        set_req(0, 4'd3, 4'd5, 2'b00);
        req_valid = 4'b0001;
        #1;
        check("single_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        check("single_alu_a", 32'(alu_a), 32'd3);
        check("single_alu_b", 32'(alu_b), 32'd5);
        check("single_wait_ready", 32'(req_ready), 32'd0);
        check("single_wait_valid", 32'(rsp_valid), 32'd0);
        tick();
        check("single_valid", 32'(rsp_valid), 32'd1);
        check("single_y", 32'(rsp_y), 32'd8);
        check("single_id", 32'(rsp_id), 32'd0);
        $display("single: rsp_id=%0d rsp_y=%0d", rsp_id, rsp_y);
        rsp_ready = 1'b1;
        tick();
        check("single_done", 32'(rsp_valid), 32'd0);
        check("single_idle", 32'(busy), 32'd0);

        // Fairness from rr_ptr=0 with all requesters valid: y_i = (i+1)+4.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_req(i, 4'(i + 1), 4'd4, 2'b00);
        end
        req_valid = 4'b1111;
        run_op(0, 5'd5);
        run_op(1, 5'd6);
        run_op(2, 5'd7);
        run_op(3, 5'd8);
        run_op(0, 5'd5);

        // rr_ptr=1; grant 2 alone moves it to 3, then 3 beats 1, then 1.
        req_valid = 4'b0100;
        run_op(2, 5'd7);
        set_req(3, 4'd4, 4'd4, 2'b11);
        req_valid = 4'b1010;
        run_op(3, 5'd4);
        check("mode_pass", 32'(alu_mode), 32'd3);
        run_op(1, 5'd6);

        // Backpressure plus full-scale operands (15+15=30); rr_ptr=2 here.
        rsp_ready = 1'b0;
        set_req(1, 4'd15, 4'd15, 2'b00);
        req_valid = 4'b0010;
        #1;
        check("bp_grant", 32'(req_ready), 32'h2);
        tick();
        req_valid = 4'b1111;
        tick();
        check("bp_valid", 32'(rsp_valid), 32'd1);
        check("ovf_y", 32'(rsp_y), 32'd30);
        for (int c = 0; c < 5; c++) begin
            tick();
            check("bp_hold_valid", 32'(rsp_valid), 32'd1);
            check("bp_hold_y", 32'(rsp_y), 32'd30);
            check("bp_hold_id", 32'(rsp_id), 32'd1);
            check("bp_ready_low", 32'(req_ready), 32'd0);
            check("bp_busy", 32'(busy), 32'd1);
            $display("bp cycle %0d: rsp_y=%0d rsp_id=%0d", c, rsp_y, rsp_id);
        end
        rsp_ready = 1'b1;
        tick();
        check("bp_release", 32'(rsp_valid), 32'd0);
        check("bp_next_grant", 32'(req_ready), 32'h4);
        req_valid = '0;

        // Reset while waiting on requester 3 aborts the operation.
        set_req(3, 4'd2, 4'd1, 2'b00);
        req_valid = 4'b1000;
        #1;
        check("abort_grant", 32'(req_ready), 32'h8);
        tick();
        req_valid = '0;
        check("abort_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("abort_valid", 32'(rsp_valid), 32'd0);
        check("abort_alu_a", 32'(alu_a), 32'd0);
        check("abort_alu_b", 32'(alu_b), 32'd0);
        check("abort_rsp_y", 32'(rsp_y), 32'd0);
        check("abort_rsp_id", 32'(rsp_id), 32'd0);
        check("abort_busy_low", 32'(busy), 32'd0);
        for (int c = 0; c < 3; c++) begin
            tick();
            check("abort_no_rsp", 32'(rsp_valid), 32'd0);
        end
        set_req(2, 4'd6, 4'd7, 2'b00);
        req_valid = 4'b0100;
        run_op(2, 5'd13);
        req_valid = '0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
